// File: rtl/sar_search_if.sv
// Comparator-side handshake of the SAR search engine: probe value out, lt/eq/gt flags back.
interface sar_search_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] guess;
  logic             probe_req;
  logic             cmp_valid;
  logic             lt;
  logic             eq;
  logic             gt;

  modport master (
    output guess,
    output probe_req,
    input  cmp_valid,
    input  lt,
    input  eq,
    input  gt
  );

  modport slave (
    input  guess,
    input  probe_req,
    output cmp_valid,
    output lt,
    output eq,
    output gt
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search: drives comparator operand "a" and binary-searches the
// hidden operand "b" from the returned lt/eq/gt flags, reporting the value and probe count.
module sar_search #(
  parameter int WIDTH   = 8,
  parameter int STEP_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  sar_search_if.master      cmp,
  output logic              busy_o,
  output logic              done_o,
  output logic              found_o,
  output logic              err_o,
  output logic [WIDTH-1:0]  result_o,
  output logic [STEP_W-1:0] steps_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [WIDTH-1:0]  ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]  ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]  TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Midpoint via a WIDTH+1-bit sum so lo+hi never wraps.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[WIDTH:1];
  endfunction

  state_t              state_q;
  logic [WIDTH-1:0]    lo_q;
  logic [WIDTH-1:0]    hi_q;
  logic [WIDTH-1:0]    guess_q;
  logic                probe_req_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                busy_q;
  logic                done_q;
  logic                found_q;
  logic                err_q;
  logic [WIDTH-1:0]    result_q;
  logic [STEP_W-1:0]   steps_q;

  logic [WIDTH-1:0]    mid_d;
  logic [WIDTH-1:0]    lo_inc_d;
  logic [WIDTH-1:0]    hi_dec_d;
  logic [2:0]          flags_d;

  // Candidate bounds for the next interval, derived from the probe currently held.
  always_comb begin
    mid_d    = midpoint(lo_q, hi_q);
    lo_inc_d = guess_q + ONE_W;
    hi_dec_d = guess_q - ONE_W;
    flags_d  = {cmp.lt, cmp.eq, cmp.gt};
  end

  // Search FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      lo_q        <= ZERO_W;
      hi_q        <= ONES_W;
      guess_q     <= ZERO_W;
      probe_req_q <= 1'b0;
      tmo_q       <= {TMO_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= ZERO_W;
      steps_q     <= {STEP_W{1'b0}};
    end else begin
      probe_req_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            lo_q     <= ZERO_W;
            hi_q     <= ONES_W;
            steps_q  <= {STEP_W{1'b0}};
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= ZERO_W;
            busy_q   <= 1'b1;
            state_q  <= S_PROBE;
          end
        end
        S_PROBE: begin
          guess_q     <= mid_d;
          probe_req_q <= 1'b1;
          steps_q     <= steps_q + STEP_ONE;
          tmo_q       <= {TMO_W{1'b0}};
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          // The probe_req cycle itself never accepts flags, nor does it count toward the timeout.
          if (probe_req_q) begin
            tmo_q <= {TMO_W{1'b0}};
          end else if (cmp.cmp_valid) begin
            case (flags_d)
              3'b010: begin
                found_q  <= 1'b1;
                result_q <= guess_q;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= S_DONE;
              end
              3'b100: begin
                if ((guess_q == ONES_W) || (lo_inc_d > hi_q)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
                end else begin
                  lo_q    <= lo_inc_d;
                  state_q <= S_PROBE;
                end
              end
              3'b001: begin
                if ((guess_q == ZERO_W) || (lo_q > hi_dec_d)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
                end else begin
                  hi_q    <= hi_dec_d;
                  state_q <= S_PROBE;
                end
              end
              default: begin
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
            endcase
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tmo_q <= tmo_q + TMO_ONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmp.guess     = guess_q;
  assign cmp.probe_req = probe_req_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign found_o       = found_q;
  assign err_o         = err_q;
  assign result_o      = result_q;
  assign steps_o       = steps_q;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: a randomized comparator responder plus an arithmetic binary-search
// reference model that predicts the probe sequence, outcome and probe count.
module tb_sar_search;
  localparam int W  = 8;
  localparam int SW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, found, err;
  logic [W-1:0]  result;
  logic [SW-1:0] steps;

  sar_search_if #(.WIDTH(W)) cmp_if ();

  sar_search #(.WIDTH(W), .STEP_W(SW), .TIMEOUT(TO)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .cmp      (cmp_if),
    .busy_o   (busy),
    .done_o   (done),
    .found_o  (found),
    .err_o    (err),
    .result_o (result),
    .steps_o  (steps)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Responder state: mode 0 = ideal comparator, 1 = lt and gt together, 2 = never answers.
  int        target = 0;
  int        mode   = 0;
  bit        noise  = 1'b0;
  int        cd     = 0;
  int        probes[$];
  int        last_probe_cyc = 0;
  int        unstable = 0;
  logic [W-1:0] held = '0;

  // Reference results.
  int exp_probes[$];
  int exp_found, exp_err, exp_result, exp_steps;
  int last_done_cyc = 0;

  always @(negedge clk) begin
    cmp_if.cmp_valid = 1'b0;
    {cmp_if.lt, cmp_if.eq, cmp_if.gt} = 3'($urandom);
    if (cmp_if.probe_req === 1'b1) begin
      probes.push_back(int'(cmp_if.guess));
      held = cmp_if.guess;
      last_probe_cyc = cyc;
      cd = $urandom_range(1, 3);
      if (noise) begin
        cmp_if.cmp_valid = 1'b1;
        {cmp_if.lt, cmp_if.eq, cmp_if.gt} = 3'b000;
      end
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        if (cmp_if.guess !== held) unstable++;
        if (mode == 0) begin
          cmp_if.cmp_valid = 1'b1;
          cmp_if.lt = (int'(held) < target);
          cmp_if.eq = (int'(held) == target);
          cmp_if.gt = (int'(held) > target);
        end else if (mode == 1) begin
          cmp_if.cmp_valid = 1'b1;
          {cmp_if.lt, cmp_if.eq, cmp_if.gt} = 3'b101;
        end
      end
    end
  end

  function automatic void build_expected(input int t, input int md);
    int lo, hi, mid;
    exp_probes.delete();
    if (md != 0) begin
      exp_probes.push_back(((1 << W) - 1) / 2);
      exp_found = 0; exp_err = 1; exp_result = 0; exp_steps = 1;
      return;
    end
    lo = 0; hi = (1 << W) - 1;
    exp_found = 0; exp_err = 0; exp_result = 0;
    while (lo <= hi) begin
      mid = (lo + hi) / 2;
      exp_probes.push_back(mid);
      if (mid == t) begin
        exp_found = 1; exp_result = t;
        break;
      end else if (mid < t) lo = mid + 1;
      else hi = mid - 1;
    end
    exp_steps = exp_probes.size();
  endfunction

  task automatic run_search(input int t, input int md, input bit spam);
    int  n_done = 0, busy_bad = 0, after = 0, bad_idx = -1;
    bit  seen = 1'b0;
    int  s_found = 0, s_err = 0, s_result = 0, s_steps = 0;
    target = t; mode = md; unstable = 0;
    probes.delete();
    build_expected(t, md);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done === 1'b1) begin
        n_done++;
        if (!seen) begin
          seen = 1'b1; last_done_cyc = cyc;
          s_found = int'(found); s_err = int'(err); s_result = int'(result); s_steps = int'(steps);
          if (busy !== 1'b0) busy_bad++;
        end
      end else if (!seen && busy !== 1'b1) busy_bad++;
      if (seen) after++;
      if (after > 4) break;
      start = (spam && !seen) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL done_timeout t=%0d: got no done, required one within 400 cycles", t); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL done_count t=%0d: got %0d, required 1", t, n_done); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL busy t=%0d: got %0d bad cycles, required 0", t, busy_bad); end
    if (probes.size() != exp_probes.size()) bad_idx = 999;
    else foreach (probes[k]) if (probes[k] != exp_probes[k] && bad_idx < 0) bad_idx = k;
    checks++; if (bad_idx >= 0) begin errors++; $display("FAIL probe_seq t=%0d: got %p, required %p", t, probes, exp_probes); end
    checks++; if (s_found != exp_found) begin errors++; $display("FAIL found t=%0d: got %0d, required %0d", t, s_found, exp_found); end
    checks++; if (s_err != exp_err) begin errors++; $display("FAIL err t=%0d: got %0d, required %0d", t, s_err, exp_err); end
    checks++; if (s_result != exp_result) begin errors++; $display("FAIL result t=%0d: got %0d, required %0d", t, s_result, exp_result); end
    checks++; if (s_steps != exp_steps) begin errors++; $display("FAIL steps t=%0d: got %0d, required %0d", t, s_steps, exp_steps); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL guess_stable t=%0d: got %0d changes, required 0", t, unstable); end
    checks++;
    if (int'(found) != exp_found || int'(err) != exp_err || int'(result) != exp_result ||
        int'(steps) != exp_steps || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold t=%0d: got found=%0d err=%0d result=%0d steps=%0d busy=%0b, required %0d %0d %0d %0d 0",
               t, found, err, result, steps, busy, exp_found, exp_err, exp_result, exp_steps);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || err !== 1'b0 || result !== '0 ||
        steps !== '0 || cmp_if.guess !== '0 || cmp_if.probe_req !== 1'b0) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b found=%b err=%b result=%0d steps=%0d guess=%0d req=%b, required all 0",
               tag, busy, done, found, err, result, steps, cmp_if.guess, cmp_if.probe_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_zero("reset_state");
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("post_reset_idle");
  endtask

  task automatic test_directed();
    noise = 1'b0;
    run_search(37, 0, 1'b0);
    run_search(127, 0, 1'b0);
    run_search(0, 0, 1'b0);
    run_search(255, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      noise = 1'($urandom_range(0, 1));
      run_search(int'($urandom_range(0, 255)), 0, 1'b0);
    end
    noise = 1'b0;
  endtask

  task automatic test_illegal_flags();
    run_search(37, 0, 1'b0);
    run_search(37, 1, 1'b0);
  endtask

  task automatic test_timeout();
    run_search(90, 0, 1'b0);
    run_search(90, 2, 1'b0);
    checks++;
    if (last_done_cyc - last_probe_cyc != TO + 1) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles probe_req->done, required %0d", last_done_cyc - last_probe_cyc, TO + 1);
    end
    mode = 0;
  endtask

  task automatic test_reset_midsearch();
    bit reached = 1'b0;
    target = 200; mode = 0; noise = 1'b0;
    probes.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (probes.size() >= 3) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!reached) begin errors++; $display("FAIL midsearch_probe3: got %0d probes, required 3", probes.size()); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_idle_zero("midsearch_reset");
    repeat (4) @(negedge clk);
    check_idle_zero("midsearch_reset_idle");
    run_search(200, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    bit got = 1'b0;
    for (int i = 0; i < 6; i++) run_search(int'($urandom_range(0, 255)), 0, 1'b1);
    target = 77; mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!got) begin errors++; $display("FAIL b2b_done: got no done, required one within 200 cycles"); end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done: got busy=%b, required 0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || cmp_if.probe_req !== 1'b0) begin
      errors++; $display("FAIL start_in_done_late: got busy=%b req=%b, required 0 0", busy, cmp_if.probe_req);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_illegal_flags();
    test_timeout();
    test_reset_midsearch();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
